// File: rtl/lsu_mem_master.sv
// Load/store unit memory master: aligns byte/half/word accesses onto a word-wide memory port.
// Latency: error T+1, single access T+2, split access T+3; one request in flight, req_ready only in IDLE.
module lsu_mem_master #(
    parameter bit SPLIT_EN = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_addr,
    output logic        mem_read,
    output logic        mem_write,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, ACC0, ACC1, DONE} state_t;

    state_t      state_q, state_d;
    logic        we_q, we_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        err_q, err_d;
    logic [31:0] word0_q, word0_d;
    // Only the low three bytes of the second word can ever reach the result.
    logic [23:0] word1_q, word1_d;

    logic [1:0]  off_q;
    logic        cross_q;
    logic        req_cross;
    logic [7:0]  wstrb_wide;
    logic [63:0] wdata_wide;
    logic [31:0] load_word;
    logic [31:0] load_ext;

    function automatic logic crosses(input logic [1:0] size, input logic [1:0] off);
        return (size == 2'b01 && off == 2'b11) || (size == 2'b10 && off != 2'b00);
    endfunction

    function automatic logic [3:0] size_mask(input logic [1:0] size);
        case (size)
            2'b00:   return 4'b0001;
            2'b01:   return 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    assign off_q     = addr_q[1:0];
    assign cross_q   = crosses(size_q, off_q);
    assign req_cross = crosses(req_size, req_addr[1:0]);

    // Low half of each wide shift is lane data for ACC0, high half is the spill into ACC1.
    assign wstrb_wide = {4'b0000, size_mask(size_q)} << off_q;
    assign wdata_wide = {32'h0, wdata_q} << {off_q, 3'b000};

    always_comb begin
        load_word = word0_q;
        case (off_q)
            2'b00: load_word = word0_q;
            2'b01: load_word = {word1_q[7:0],  word0_q[31:8]};
            2'b10: load_word = {word1_q[15:0], word0_q[31:16]};
            2'b11: load_word = {word1_q[23:0], word0_q[31:24]};
        endcase
    end

    always_comb begin
        load_ext = load_word;
        case (size_q)
            2'b00:   load_ext = uns_q ? {24'h0, load_word[7:0]}
                                      : {{24{load_word[7]}}, load_word[7:0]};
            2'b01:   load_ext = uns_q ? {16'h0, load_word[15:0]}
                                      : {{16{load_word[15]}}, load_word[15:0]};
            default: load_ext = load_word;
        endcase
    end

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        size_d  = size_q;
        uns_d   = uns_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        err_d   = err_q;
        word0_d = word0_q;
        word1_d = word1_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    size_d  = req_size;
                    uns_d   = req_unsigned;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    word0_d = 32'h0;
                    word1_d = 24'h0;
                    if (req_size == 2'b11 || (req_cross && !SPLIT_EN)) begin
                        err_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        err_d   = 1'b0;
                        state_d = ACC0;
                    end
                end
            end
            ACC0: begin
                if (!we_q) word0_d = mem_rdata;
                state_d = cross_q ? ACC1 : DONE;
            end
            ACC1: begin
                if (!we_q) word1_d = mem_rdata[23:0];
                state_d = DONE;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            err_q   <= 1'b0;
            word0_q <= 32'h0;
            word1_q <= 24'h0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
            word0_q <= word0_d;
            word1_q <= word1_d;
        end
    end

    // Outputs decode straight from state so an async reset silences them at once.
    always_comb begin
        req_ready  = (state_q == IDLE);
        resp_valid = 1'b0;
        resp_err   = 1'b0;
        resp_rdata = 32'h0;
        mem_addr   = 32'h0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_wstrb  = 4'b0000;
        mem_wdata  = 32'h0;
        case (state_q)
            ACC0: begin
                mem_addr  = {addr_q[31:2], 2'b00};
                mem_read  = !we_q;
                mem_write = we_q;
                mem_wstrb = we_q ? wstrb_wide[3:0] : 4'b0000;
                mem_wdata = wdata_wide[31:0];
            end
            ACC1: begin
                mem_addr  = {addr_q[31:2], 2'b00} + 32'd4;
                mem_read  = !we_q;
                mem_write = we_q;
                mem_wstrb = we_q ? wstrb_wide[7:4] : 4'b0000;
                mem_wdata = wdata_wide[63:32];
            end
            DONE: begin
                resp_valid = 1'b1;
                resp_err   = err_q;
                resp_rdata = (we_q || err_q) ? 32'h0 : load_ext;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_lsu_mem_master.sv
// Directed bench for lsu_mem_master: split/aligned loads and stores, errors, wrap and mid-access reset.
module tb_lsu_mem_master;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_valid_b;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr, req_wdata;

    logic        req_ready, resp_valid, resp_err, mem_read, mem_write;
    logic [31:0] resp_rdata, mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;

    logic        req_ready_b, resp_valid_b, resp_err_b, mem_read_b, mem_write_b;
    logic [31:0] resp_rdata_b, mem_addr_b, mem_wdata_b, mem_rdata_b;
    logic [3:0]  mem_wstrb_b;

    logic [31:0] mem [0:15];
    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    assign mem_rdata   = mem[mem_addr[5:2]];
    assign mem_rdata_b = 32'h0;

    always @(posedge clk) begin
        if (mem_write) begin
            for (int i = 0; i < 4; i++)
                if (mem_wstrb[i]) mem[mem_addr[5:2]][8*i +: 8] = mem_wdata[8*i +: 8];
        end
    end

    lsu_mem_master #(.SPLIT_EN(1'b1)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write),
        .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    lsu_mem_master #(.SPLIT_EN(1'b0)) dut_b (
        .clk(clk), .reset(reset),
        .req_valid(req_valid_b), .req_ready(req_ready_b), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid_b), .resp_rdata(resp_rdata_b), .resp_err(resp_err_b),
        .mem_addr(mem_addr_b), .mem_read(mem_read_b), .mem_write(mem_write_b),
        .mem_wstrb(mem_wstrb_b), .mem_wdata(mem_wdata_b), .mem_rdata(mem_rdata_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Presents one request for one cycle; returns at the negedge right after the acceptance edge.
    task automatic send(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] wd, input logic to_b);
        @(negedge clk);
        req_we = we; req_size = sz; req_unsigned = uns; req_addr = a; req_wdata = wd;
        if (to_b) req_valid_b = 1'b1;
        else      req_valid   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0; req_valid_b = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
        mem[0]  = 32'h88776655;
        mem[1]  = 32'h44332211;
        mem[15] = 32'h12345678;
        reset = 1'b1;
        req_valid = 1'b0; req_valid_b = 1'b0; req_we = 1'b0; req_size = 2'b00;
        req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
        #1;
        chk("rst_ready",  {31'h0, req_ready},  32'h1);
        chk("rst_valid",  {31'h0, resp_valid}, 32'h0);
        chk("rst_err",    {31'h0, resp_err},   32'h0);
        chk("rst_rdata",  resp_rdata, 32'h0);
        chk("rst_rdwr",   {30'h0, mem_read, mem_write}, 32'h0);
        chk("rst_addr",   mem_addr, 32'h0);
        chk("rst_wstrb",  {28'h0, mem_wstrb}, 32'h0);
        chk("rst_wdata",  mem_wdata, 32'h0);
        @(negedge clk); @(negedge clk);
        reset = 1'b0;

        // lw 0x2: split, busy-time input changes must be ignored
        send(1'b0, 2'b10, 1'b0, 32'h2, 32'h0, 1'b0);
        req_addr = 32'h30; req_size = 2'b00; req_unsigned = 1'b1;
        chk("lw2_acc0_addr", mem_addr, 32'h0);
        chk("lw2_acc0_rd",   {30'h0, mem_read, mem_write}, 32'h2);
        chk("lw2_acc0_rdy",  {31'h0, req_ready}, 32'h0);
        @(negedge clk);
        chk("lw2_acc1_addr", mem_addr, 32'h4);
        chk("lw2_acc1_rd",   {30'h0, mem_read, mem_write}, 32'h2);
        chk("lw2_acc1_vld",  {31'h0, resp_valid}, 32'h0);
        @(negedge clk);
        chk("lw2_vld",   {31'h0, resp_valid}, 32'h1);
        chk("lw2_rdata", resp_rdata, 32'h22118877);
        chk("lw2_err",   {31'h0, resp_err}, 32'h0);
        chk("lw2_idle",  {30'h0, mem_read, mem_write}, 32'h0);
        @(negedge clk);
        chk("lw2_after_vld", {31'h0, resp_valid}, 32'h0);
        chk("lw2_after_rdy", {31'h0, req_ready}, 32'h1);

        // lb / lbu 0x3: single access, response at T+2
        send(1'b0, 2'b00, 1'b0, 32'h3, 32'h0, 1'b0);
        chk("lb3_acc0_addr", mem_addr, 32'h0);
        @(negedge clk);
        chk("lb3_vld",   {31'h0, resp_valid}, 32'h1);
        chk("lb3_rdata", resp_rdata, 32'hFFFFFF88);
        send(1'b0, 2'b00, 1'b1, 32'h3, 32'h0, 1'b0);
        @(negedge clk);
        chk("lbu3_vld",   {31'h0, resp_valid}, 32'h1);
        chk("lbu3_rdata", resp_rdata, 32'h00000088);

        // lh 0x3: split, response at T+3
        send(1'b0, 2'b01, 1'b0, 32'h3, 32'h0, 1'b0);
        @(negedge clk);
        chk("lh3_acc1_addr", mem_addr, 32'h4);
        chk("lh3_t2_vld",    {31'h0, resp_valid}, 32'h0);
        @(negedge clk);
        chk("lh3_vld",   {31'h0, resp_valid}, 32'h1);
        chk("lh3_rdata", resp_rdata, 32'h00001188);

        // sh 0xABCD at 0x3: split store
        send(1'b1, 2'b01, 1'b0, 32'h3, 32'h0000ABCD, 1'b0);
        chk("sh3_acc0_addr",  mem_addr, 32'h0);
        chk("sh3_acc0_wr",    {30'h0, mem_read, mem_write}, 32'h1);
        chk("sh3_acc0_wstrb", {28'h0, mem_wstrb}, 32'h8);
        chk("sh3_acc0_wdata", mem_wdata, 32'hCD000000);
        @(negedge clk);
        chk("sh3_acc1_addr",  mem_addr, 32'h4);
        chk("sh3_acc1_wstrb", {28'h0, mem_wstrb}, 32'h1);
        chk("sh3_acc1_wdata", mem_wdata, 32'h000000AB);
        @(negedge clk);
        chk("sh3_vld",   {31'h0, resp_valid}, 32'h1);
        chk("sh3_rdata", resp_rdata, 32'h0);
        chk("sh3_mem0",  mem[0], 32'hCD776655);
        chk("sh3_mem1",  mem[1], 32'h443322AB);

        // illegal size: error at T+1, no memory strobes
        send(1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 1'b0);
        chk("ill_vld",  {31'h0, resp_valid}, 32'h1);
        chk("ill_err",  {31'h0, resp_err}, 32'h1);
        chk("ill_rdwr", {30'h0, mem_read, mem_write}, 32'h0);
        chk("ill_rdata", resp_rdata, 32'h0);

        // SPLIT_EN=0 instance: crossing lw is an error at T+1
        send(1'b0, 2'b10, 1'b0, 32'h1, 32'h0, 1'b1);
        chk("nosplit_vld",  {31'h0, resp_valid_b}, 32'h1);
        chk("nosplit_err",  {31'h0, resp_err_b}, 32'h1);
        chk("nosplit_rdwr", {30'h0, mem_read_b, mem_write_b}, 32'h0);
        chk("nosplit_main_idle", {31'h0, resp_valid}, 32'h0);

        // lw 0xFFFFFFFE: second access wraps to 0
        send(1'b0, 2'b10, 1'b0, 32'hFFFFFFFE, 32'h0, 1'b0);
        chk("wrap_acc0_addr", mem_addr, 32'hFFFFFFFC);
        @(negedge clk);
        chk("wrap_acc1_addr", mem_addr, 32'h0);
        @(negedge clk);
        chk("wrap_rdata", resp_rdata, 32'h66551234);

        // sb 0x5A at 0x5: aligned single store
        send(1'b1, 2'b00, 1'b0, 32'h5, 32'h0000005A, 1'b0);
        chk("sb5_addr",  mem_addr, 32'h4);
        chk("sb5_wstrb", {28'h0, mem_wstrb}, 32'h2);
        chk("sb5_wdata", mem_wdata, 32'h00005A00);
        @(negedge clk);
        chk("sb5_vld",  {31'h0, resp_valid}, 32'h1);
        chk("sb5_mem1", mem[1], 32'h44335AAB);

        // reset during ACC0 of split sw 0x2
        send(1'b1, 2'b10, 1'b0, 32'h2, 32'hDEADBEEF, 1'b0);
        chk("rsw_acc0_wr",    {30'h0, mem_read, mem_write}, 32'h1);
        chk("rsw_acc0_wstrb", {28'h0, mem_wstrb}, 32'hC);
        chk("rsw_acc0_wdata", mem_wdata, 32'hBEEF0000);
        #1 reset = 1'b1;
        #1;
        chk("rsw_wr_drop", {30'h0, mem_read, mem_write}, 32'h0);
        chk("rsw_addr",    mem_addr, 32'h0);
        chk("rsw_wstrb",   {28'h0, mem_wstrb}, 32'h0);
        chk("rsw_ready",   {31'h0, req_ready}, 32'h1);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("rsw_no_resp", {31'h0, resp_valid}, 32'h0);
            chk("rsw_no_wr",   {31'h0, mem_write}, 32'h0);
            @(negedge clk);
        end
        chk("rsw_mem0", mem[0], 32'hCD776655);
        chk("rsw_mem1", mem[1], 32'h44335AAB);
        chk("rsw_ready_end", {31'h0, req_ready}, 32'h1);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule

// File: doc/lsu_mem_master.md
LSU_MEM_MASTER -- requirements
Module: lsu_mem_master

Interface
REQ-001 SHALL have parameter SPLIT_EN, default 1, meaning 1 = split word-crossing accesses into two memory cycles and 0 = flag them as errors.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port req_valid, input, 1 bit: pipeline request present.
REQ-005 SHALL have port req_ready, output, 1 bit: unit can accept a request.
REQ-006 SHALL have port req_we, input, 1 bit: 1 = store, 0 = load.
REQ-007 SHALL have port req_size, input, 2 bits: 00 byte, 01 halfword, 10 word, 11 illegal.
REQ-008 SHALL have port req_unsigned, input, 1 bit: 0 = sign-extend, 1 = zero-extend on loads.
REQ-009 SHALL have port req_addr, input, 32 bits: byte address.
REQ-010 SHALL have port req_wdata, input, 32 bits: store data, right-aligned.
REQ-011 SHALL have port resp_valid, output, 1 bit: one-cycle completion pulse.
REQ-012 SHALL have port resp_rdata, output, 32 bits: extended load result; 0 for stores and errors.
REQ-013 SHALL have port resp_err, output, 1 bit: illegal size, or crossing access with SPLIT_EN=0; valid with resp_valid.
REQ-014 SHALL have port mem_addr, output, 32 bits: word-aligned address, bits [1:0] always 00.
REQ-015 SHALL have port mem_read, output, 1 bit: word read strobe.
REQ-016 SHALL have port mem_write, output, 1 bit: word write strobe, committed on the clk edge.
REQ-017 SHALL have port mem_wstrb, output, 4 bits: byte-lane enables, bit n = byte n.
REQ-018 SHALL have port mem_wdata, output, 32 bits: lane-shifted store data.
REQ-019 SHALL have port mem_rdata, input, 32 bits: combinational read data, valid in the same cycle as mem_read.

Function
REQ-020 SHALL implement FSM states IDLE, ACC0, ACC1, DONE.
REQ-021 SHALL assert req_ready only in IDLE; a request is accepted when req_valid and req_ready are both high, and all req_* fields are registered.
REQ-022 SHALL, on acceptance, go to DONE with resp_err=1 and issue no memory access if size=11, or if the access crosses a word boundary and SPLIT_EN=0; otherwise go to ACC0.
REQ-023 SHALL treat an access as crossing when (halfword and off=3) or (word and off!=0), where off=req_addr[1:0].
REQ-024 SHALL, in ACC0, drive mem_addr={addr[31:2],00}, wstrb0 = (size mask 0001/0011/1111) << off truncated to 4 bits, and wdata0 = req_wdata << 8*off; the next state is ACC1 if crossing, else DONE.
REQ-025 SHALL, in ACC1, drive mem_addr = ACC0 address + 4 (0xFFFFFFFC wraps to 0x00000000), wstrb1 = size mask >> (4-off), and wdata1 = req_wdata >> 8*(4-off); the next state is DONE.
REQ-026 SHALL, in ACC0/ACC1, assert mem_read for loads or mem_write for stores (never both), with wstrb=0000 on loads; mem_rdata is captured at the end of each load cycle.
REQ-027 SHALL, in DONE, hold resp_valid=1 for exactly one cycle and then return to IDLE; no back-to-back overlap is allowed, and the next acceptance is earliest in the cycle after DONE.
REQ-028 SHALL form the load result as ({word1,word0} >> 8*off), then take bits [7:0] or [15:0] or [31:0] and sign/zero-extend per req_unsigned; word1=0 when not crossing.
REQ-029 SHALL have latency from acceptance edge T to resp_valid: T+1 for error, T+2 for a single access, T+3 for a split access.
REQ-030 SHALL keep mem_read, mem_write and mem_wstrb at 0, and mem_addr and mem_wdata at 0, outside ACC0/ACC1.
REQ-031 SHALL ignore req_valid and input changes while not in IDLE.

Reset
REQ-032 SHALL, on reset assertion, immediately (asynchronously) force state to IDLE and drive req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, mem_read=0, mem_write=0, mem_wstrb=0, mem_addr=0, mem_wdata=0.
REQ-033 SHALL, on reset mid-operation, drop the pending request with no response; an ACC1 store half not yet written is never written, and an ACC0 half already committed is not rolled back.

Verification
REQ-034 SHALL be verified with: memory word 0x0=0x88776655, word 0x4=0x44332211; lw addr 0x2 -> ACC0 addr 0x0, ACC1 addr 0x4, resp_rdata=0x22118877 at T+3.
REQ-035 SHALL be verified with: same memory; lb addr 0x3 -> 0xFFFFFF88 at T+2; lbu addr 0x3 -> 0x00000088; lh addr 0x3 -> 0x00001188 at T+3.
REQ-036 SHALL be verified with: sh 0x0000ABCD addr 0x3 -> ACC0 addr 0x0 wstrb 1000 wdata 0xCD000000; ACC1 addr 0x4 wstrb 0001 wdata 0x000000AB; resp_valid at T+3 with rdata 0.
REQ-037 SHALL be verified with: req_size=11 addr 0x10 -> resp_err=1 at T+1, with mem_read and mem_write never asserted.
REQ-038 SHALL be verified with: SPLIT_EN=0, lw addr 0x1 -> resp_err=1 at T+1, no access; lw addr 0xFFFFFFFE with SPLIT_EN=1 -> accesses at 0xFFFFFFFC then 0x00000000.
REQ-039 SHALL be verified with: reset asserted during ACC0 of split sw addr 0x2 -> mem_write drops the same cycle, no ACC1 write, no resp_valid, req_ready=1.
